phy_tx_serializer_n: RTL and testbench

//  Parametrised next-generation PHY transmitter: takes DATA_W-bit words over a valid/ready

---
 rtl/phy_tx_pkg.sv | 15 +
 rtl/phy_tx_fifo.sv | 43 ++++
 rtl/phy_tx_serializer_n.sv | 81 ++++++++
 tb/tb_phy_tx_serializer_n.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg: symbols, state encoding and helpers shared by the PHY transmit and receive sides.
package phy_tx_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;
    localparam int REP_MAX = 256;

    typedef enum logic {TRAIN, ACTIVE} state_t;

    // Callers truncate the result to their own slice width (a multiple of 8, at most REP_MAX).
    function automatic logic [REP_MAX-1:0] rep_byte(input logic [7:0] b);
        return {(REP_MAX/8){b}};
    endfunction

endpackage

// File: rtl/phy_tx_fifo.sv
// phy_tx_fifo: small synchronous word FIFO; push is ignored when full, pop when empty.
module phy_tx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_32f,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end

    always_ff @(posedge clk_32f)
        if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/phy_tx_serializer_n.sv
// phy_tx_serializer_n: buffers words and serialises each across LANES lanes, with a COM
// training phase after reset and IDL fill when no data is queued.
module phy_tx_serializer_n
    import phy_tx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LANES       = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TRAIN_SLOTS = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] Data_in,
    output logic              ready_out,
    output logic [LANES-1:0]  Data_out,
    output logic              active_out,
    output logic              slot_start
);
    localparam int SLICE_W = DATA_W / LANES;
    localparam int BW      = $clog2(SLICE_W);
    localparam int TW      = $clog2(TRAIN_SLOTS + 1);
    localparam logic [SLICE_W-1:0] COM_W = SLICE_W'(rep_byte(COM));
    localparam logic [SLICE_W-1:0] IDL_W = SLICE_W'(rep_byte(IDL));

    logic [BW-1:0]     bit_cnt;
    logic [TW-1:0]     train_cnt, train_cnt_n;
    state_t            state, state_n;
    logic              boundary, go_active, full, empty, pop;
    logic [DATA_W-1:0] head;

    assign boundary   = bit_cnt == BW'(SLICE_W - 1);
    // The slot loaded once training has run its course is already an ACTIVE slot.
    assign go_active  = state == ACTIVE || train_cnt == TW'(TRAIN_SLOTS);
    assign pop        = boundary & go_active & !empty;
    assign ready_out  = reset & !full;
    assign active_out = state == ACTIVE;

    phy_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_32f(clk_32f),
        .reset  (reset),
        .push   (valid_in & ready_out),
        .pop    (pop),
        .din    (Data_in),
        .full   (full),
        .empty  (empty),
        .dout   (head)
    );

    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) begin
            state      <= TRAIN;
            train_cnt  <= '0;
            bit_cnt    <= BW'(SLICE_W - 1);
            slot_start <= 1'b0;
        end else begin
            state      <= state_n;
            train_cnt  <= train_cnt_n;
            bit_cnt    <= boundary ? '0 : bit_cnt + 1'b1;
            slot_start <= boundary;
        end

    always_comb begin
        state_n     = state;
        train_cnt_n = train_cnt;
        if (boundary) begin
            if (go_active) state_n = ACTIVE;
            else train_cnt_n = train_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [SLICE_W-1:0] sh, load;
        assign load = !go_active ? COM_W : empty ? IDL_W : head[(LANES-k)*SLICE_W-1 -: SLICE_W];
        always_ff @(posedge clk_32f or negedge reset)
            if (!reset) sh <= '0;
            else sh <= boundary ? load : sh << 1;
        assign Data_out[k] = sh[SLICE_W-1];
    end

endmodule

// File: tb/tb_phy_tx_serializer_n.sv
// tb_phy_tx_serializer_n: random and directed stimulus against a slot-level reference model,
// plus a 4-lane build checked with a directed word.
module tb_phy_tx_serializer_n;
    localparam int S     = 16;
    localparam int L     = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TS    = 4;

    logic          clk_32f, reset, valid_in, ready_out, active_out, slot_start;
    logic [DW-1:0] Data_in;
    logic [L-1:0]  Data_out;
    logic          valid2, ready2, active2, slot2;
    logic [63:0]   data2;
    logic [3:0]    dout2;

    phy_tx_serializer_n dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .valid_in  (valid_in),
        .Data_in   (Data_in),
        .ready_out (ready_out),
        .Data_out  (Data_out),
        .active_out(active_out),
        .slot_start(slot_start)
    );

    phy_tx_serializer_n #(.DATA_W(64), .LANES(4)) dut4 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .valid_in  (valid2),
        .Data_in   (data2),
        .ready_out (ready2),
        .Data_out  (dout2),
        .active_out(active2),
        .slot_start(slot2)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int            checks = 0, errors = 0;
    logic [DW-1:0] q[$];
    int            e = -1;
    logic [S-1:0]  cur [L];
    bit            acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [S-1:0] fill(input logic [7:0] b);
        return {(S/8){b}};
    endfunction

    task automatic model_reset();
        q.delete();
        e   = -1;
        acc = 0;
    endtask

    // Slot-level view: edge e after release, slot n = e/S; the first TS slots are COM.
    task automatic model_edge();
        int            pre, n;
        logic [DW-1:0] w;
        if (!reset) begin
            model_reset();
            return;
        end
        e++;
        pre = q.size();
        acc = valid_in && pre < DEPTH;
        if (e % S == 0) begin
            n = e / S;
            if (n < TS) for (int k = 0; k < L; k++) cur[k] = fill(8'hBC);
            else if (pre > 0) begin
                w = q.pop_front();
                for (int k = 0; k < L; k++) cur[k] = w[(L-k)*S-1 -: S];
            end else for (int k = 0; k < L; k++) cur[k] = fill(8'h7C);
        end
        if (acc) q.push_back(Data_in);
    endtask

    task automatic expect_outputs();
        logic [L-1:0] d;
        bit           run;
        run = reset && e >= 0;
        d = '0;
        if (run) for (int k = 0; k < L; k++) d[k] = cur[k][S-1-(e%S)];
        check("data_out", 64'(Data_out), 64'(d));
        check("slot_start", 64'(slot_start), 64'(run && e % S == 0));
        check("active_out", 64'(active_out), 64'(run && e / S >= TS));
        check("ready_out", 64'(ready_out), 64'(reset && q.size() < DEPTH));
    endtask

    task automatic step();
        @(posedge clk_32f);
        model_edge();
        @(negedge clk_32f);
        expect_outputs();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] words [6];
        logic [15:0]   lane4 [4];
        logic [63:0]   w6;
        int            got, guard;
        reset    = 1'b0;
        valid_in = 1'b0;
        Data_in  = '0;
        valid2   = 1'b0;
        data2    = '0;
        repeat (3) step();
        reset = 1'b1;
        // Training then idle fill
        repeat (96) step();
        // Two back-to-back words
        valid_in = 1'b1;
        Data_in  = 32'hFFFFFFFF;
        step();
        Data_in = 32'hEEEEEEEE;
        step();
        valid_in = 1'b0;
        repeat (48) step();
        // Push landing exactly on a boundary edge
        while ((e + 1) % S != 0) step();
        valid_in = 1'b1;
        Data_in  = 32'h00000003;
        step();
        valid_in = 1'b0;
        repeat (40) step();
        // Reset mid-slot with words queued
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            Data_in  = $urandom;
            step();
        end
        valid_in = 1'b0;
        repeat (5) step();
        check("queued_before_reset", 64'(q.size() >= 2), 64'd1);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check("rst_data_out", 64'(Data_out), 64'd0);
        check("rst_ready_out", 64'(ready_out), 64'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (96) step();
        // Six words offered during training
        pulse_reset();
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        got = 0;
        guard = 0;
        valid_in = 1'b1;
        Data_in  = words[0];
        while (got < 6 && guard < 200) begin
            step();
            guard++;
            if (acc) begin
                got++;
                if (got < 6) Data_in = words[got];
            end
        end
        valid_in = 1'b0;
        check("t3_accepts", 64'(got), 64'd6);
        repeat (120) step();
        // Random traffic
        repeat (1500) begin
            valid_in = $urandom_range(0, 2) == 0;
            Data_in  = $urandom;
            step();
        end
        valid_in = 1'b0;
        repeat (100) step();
        // Four-lane build
        pulse_reset();
        guard = 0;
        while (!active2 && guard < 300) begin
            step();
            guard++;
        end
        check("t6_active", 64'(active2), 64'd1);
        w6 = 64'h0123456789ABCDEF;
        check("t6_ready", 64'(ready2), 64'd1);
        valid2 = 1'b1;
        data2  = w6;
        step();
        valid2 = 1'b0;
        guard = 0;
        while (!slot2 && guard < 40) begin
            step();
            guard++;
        end
        check("t6_slot", 64'(slot2), 64'd1);
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 4; k++) lane4[k][15-b] = dout2[k];
            if (b < 15) step();
        end
        for (int k = 0; k < 4; k++) check($sformatf("t6_lane%0d", k), 64'(lane4[k]), 64'(w6[(4-k)*16-1 -: 16]));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
